// File: rtl/alu_sm_seq.sv
// alu_sm_seq: handshaked multi-cycle add/sub/shift-add multiply with sign-magnitude result
//   clk, rst                : clock, asynchronous active-high reset
//   in_valid/in_ready       : operand bundle handshake (in_ready = IDLE)
//   op, a, b                : 00 ADD, 01 SUB, 10 MUL, 11 illegal; unsigned W-bit operands
//   out_valid/out_ready     : result handshake (out_valid = DONE)
//   result, sign, zero, err : 2W-bit magnitude, negative flag, zero flag, illegal-op flag
module alu_sm_seq #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] result,
    output logic           sign,
    output logic           zero,
    output logic           err
);
    localparam int CW = $clog2(W);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t           r_state, w_next;
    logic [W-1:0]     r_a, r_b;
    logic [1:0]       r_op;
    logic [CW-1:0]    r_cnt;
    logic [2*W-1:0]   r_acc, r_result, w_acc_nxt;
    logic             r_sign, r_zero, r_err;
    logic [W:0]       w_sum;
    logic [W-1:0]     w_diff;
    logic             w_ge, w_last;
    assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
    assign w_ge      = r_a >= r_b;
    assign w_diff    = w_ge ? r_a - r_b : r_b - r_a;
    // one multiplier bit per cycle, LSB first
    assign w_acc_nxt = r_acc + (r_b[r_cnt] ? ({{W{1'b0}}, r_a} << r_cnt) : '0);
    assign w_last    = r_cnt == CW'(W - 1);
    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign result    = r_result;
    assign sign      = r_sign;
    assign zero      = r_zero;
    assign err       = r_err;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && in_valid) w_next = EXEC;
        else if (r_state == EXEC && (r_op != 2'b10 || w_last)) w_next = DONE;
        else if (r_state == DONE && out_ready) w_next = IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_sign   <= 1'b0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_op  <= op;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_state == EXEC) begin
            case (r_op)
                2'b00: begin
                    r_result <= {{(W-1){1'b0}}, w_sum};
                    r_sign   <= 1'b0;
                    r_zero   <= w_sum == '0;
                    r_err    <= 1'b0;
                end
                2'b01: begin
                    r_result <= {{W{1'b0}}, w_diff};
                    r_sign   <= !w_ge;
                    r_zero   <= w_diff == '0;
                    r_err    <= 1'b0;
                end
                2'b10: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_result <= w_acc_nxt;
                        r_sign   <= 1'b0;
                        r_zero   <= w_acc_nxt == '0;
                        r_err    <= 1'b0;
                    end
                end
                default: begin
                    r_result <= '0;
                    r_sign   <= 1'b0;
                    r_zero   <= 1'b0;
                    r_err    <= 1'b1;
                end
            endcase
        end
    end
endmodule
